// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, legality check and the
// arbiter state encoding. Also used by ALU_Control and the ALU itself.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True for the five operations the shared ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The last-grant pointer is owned by the
// caller; a tie goes to the requester that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // One-hot grant, all-zero when disabled or nobody requests.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the main datapath (requester 0)
// and the address/branch-compare helper (requester 1). One transaction
// at a time: IDLE (grant) -> EXEC (drive ALU, capture) -> RESP (hold).
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. A requester holds valid and payload stable until ready;
// the block holds rspN_valid and the rsp_* payload stable until rspN_ready.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_id_q, gnt_id_d;
  // op_q holds the op actually sent to the ALU: illegal codes are stored
  // as ADD so the ALU never sees them, and err_q remembers the fault.
  logic [3:0]       op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       gnt;
  logic             rsp_hs;
  logic [3:0]       sel_op;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .en         (state_q == ST_IDLE),
    .gnt        (gnt)
  );

  // Request-side ready is the grant itself; grant is only ever given in IDLE.
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign sel_op = gnt[1] ? req1_op : req0_op;
  assign rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  // Next-state and next-register values for the whole transaction flow.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    op_d         = op_q;
    err_d        = err_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          gnt_id_d     = gnt[1];
          last_grant_d = gnt[1];
          op_d         = is_legal_op(sel_op) ? sel_op : OP_ADD;
          err_d        = ~is_legal_op(sel_op);
          a_d          = gnt[1] ? req1_a : req0_a;
          b_d          = gnt[1] ? req1_b : req0_b;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = err_q ? '0 : alu_result;
        rsp_zero_d   = err_q ? 1'b1 : alu_zero;
        rsp_err_d    = err_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      op_q         <= OP_ADD;
      err_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      op_q         <= op_d;
      err_q        <= err_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign rsp0_valid = (state_q == ST_RESP) & ~gnt_id_q;
  assign rsp1_valid = (state_q == ST_RESP) &  gnt_id_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural external ALU.
module tb_alu_share_arbiter;
  localparam int W = 64;

  logic         clk, reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic         rsp_zero, rsp_err, alu_zero, busy;
  logic [3:0]   alu_op;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .dbg_state(dbg_state)
  );

  // External ALU model (environment, not a copy of the arbiter).
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a << alu_b[5:0];
      default: alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic v, input logic [3:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
    else         begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  // One transaction from a single requester; optional response stall
  // during which the other requester is kept valid to show it is blocked.
  task automatic txn(input string tag, input int id, input logic [3:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp_res, input logic exp_zero,
                     input logic exp_err, input int hold);
    logic got_ready;
    logic [3:0] exp_aluop;
    exp_aluop = (op == 4'b0000 || op == 4'b0001 || op == 4'b0010 ||
                 op == 4'b0110 || op == 4'b1000) ? op : 4'b0010;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_req(id, 1'b1, op, a, b);
    got_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got_ready = (id == 0) ? req0_ready : req1_ready;
      if (got_ready) break;
      @(posedge clk); #1;
    end
    check({tag, "_grant"}, {63'd0, got_ready}, 64'd1);
    @(posedge clk); #1;                       // accept edge (cycle N)
    drive_req(id, 1'b0, 4'd0, '0, '0);
    @(negedge clk);                           // cycle N+1: EXEC
    check({tag, "_exec_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_exec_aluop"}, {60'd0, alu_op}, {60'd0, exp_aluop});
    check({tag, "_exec_alua"}, alu_a, a);
    check({tag, "_exec_rspv"}, {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);                           // cycle N+2: RESP
    check({tag, "_rspv"}, {62'd0, rsp1_valid, rsp0_valid}, (id == 0) ? 64'd1 : 64'd2);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_zero_err"}, {62'd0, rsp_zero, rsp_err}, {62'd0, exp_zero, exp_err});
    if (hold > 0) drive_req(1 - id, 1'b1, 4'b0010, 64'd1, 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_rspv"}, {62'd0, rsp1_valid, rsp0_valid}, (id == 0) ? 64'd1 : 64'd2);
      check({tag, "_hold_result"}, rsp_result, exp_res);
      check({tag, "_hold_ready"}, {61'd0, busy, req1_ready, req0_ready}, 64'd4);
    end
    @(posedge clk); #1;
    drive_req(1 - id, 1'b0, 4'd0, '0, '0);
    if (id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk); #1;                       // response handshake
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, {61'd0, busy, rsp1_valid, rsp0_valid}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_req(0, 1'b0, 4'd0, '0, '0);
    drive_req(1, 1'b0, 4'd0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valids", {60'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 64'd0);
    check("rst_aluop", {60'd0, alu_op}, 64'd2);
    check("rst_alua_b", alu_a | alu_b, 64'd0);
    check("rst_rsp", {rsp_result[61:0], rsp_zero, rsp_err}, 64'd0);
    @(posedge clk); #1;

    // Tie after reset and fairness: 6 back-to-back transactions, 3 cycles each.
    drive_req(0, 1'b1, 4'b0110, 64'd9, 64'd9);
    drive_req(1, 1'b1, 4'b0001, 64'h0F, 64'hF0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int e;
      e = i % 2;
      @(negedge clk);                          // IDLE
      check("fair_ready", {61'd0, busy, req1_ready, req0_ready}, (e == 0) ? 64'd1 : 64'd2);
      @(posedge clk); #1;
      if (i == 5) begin
        drive_req(0, 1'b0, 4'd0, '0, '0);
        drive_req(1, 1'b0, 4'd0, '0, '0);
      end
      @(negedge clk);                          // EXEC
      check("fair_exec_busy", {63'd0, busy}, 64'd1);
      @(posedge clk);
      @(negedge clk);                          // RESP
      check("fair_rspv", {62'd0, rsp1_valid, rsp0_valid}, (e == 0) ? 64'd1 : 64'd2);
      check("fair_result", rsp_result, (e == 0) ? 64'd0 : 64'hFF);
      check("fair_zero_err", {62'd0, rsp_zero, rsp_err}, (e == 0) ? 64'd2 : 64'd0);
      @(posedge clk);                          // handshake
    end
    #1 rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    check("fair_end_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Single request, backpressure, illegal op.
    txn("single", 0, 4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 0);
    txn("bp", 1, 4'b1000, 64'd1, 64'd4, 64'd16, 1'b0, 1'b0, 3);
    txn("illegal", 0, 4'b1111, 64'd3, 64'd4, 64'd0, 1'b1, 1'b1, 0);
    txn("and", 1, 4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 0);

    // Reset during EXEC drops the request; pointer returns to 1.
    drive_req(0, 1'b1, 4'b0010, 64'd2, 64'd3);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    check("rmid_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(posedge clk); #1;                        // accepted, now EXEC
    drive_req(0, 1'b0, 4'd0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rmid_idle", {61'd0, busy, rsp1_valid, rsp0_valid}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rmid_no_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_req(0, 1'b1, 4'b0010, 64'd1, 64'd1);
    drive_req(1, 1'b1, 4'b0010, 64'd1, 64'd1);
    @(negedge clk);
    check("rmid_tie", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 4'd0, '0, '0);
    drive_req(1, 1'b0, 4'd0, '0, '0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
